// File: rtl/jk_pkg.sv
// Shared types for the JK bank driver: FSM state enum and {j,k} excitation encodings.
package jk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        RESP  = 2'd3
    } jk_state_e;

    // Two-bit excitation codes, ordered {j, k}.
    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

endpackage

// File: rtl/jk_excite.sv
// Combinational per-bit J/K excitation from current Q and target; zero when not enabled.
// JK_DRV_TOGGLE_EN selects toggle (1/1) instead of set/reset for mismatching bits.
module jk_excite
    import jk_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] q,
    input  logic [N-1:0] tgt,
    input  logic         en,
    output logic [N-1:0] j,
    output logic [N-1:0] k
);

    always_comb begin
        logic [1:0] code;
        code = JK_HOLD;
        j    = '0;
        k    = '0;
        for (int i = 0; i < N; i++) begin
            if (q[i] == tgt[i]) begin
                code = JK_HOLD;
            end else begin
`ifdef JK_DRV_TOGGLE_EN
                code = JK_TOGGLE;
`else
                code = tgt[i] ? JK_SET : JK_RESET;
`endif
            end
            j[i] = en & code[1];
            k[i] = en & code[0];
        end
    end

endmodule

// File: rtl/jk_driver.sv
// Write-side sequencer for a JK register bank: accept target, drive one cycle, verify Q, retry or report.
// done/err 2 cycles after accept (+2 per retry); tgt_ready only in IDLE. Option: JK_DRV_TOGGLE_EN.
module jk_driver
    import jk_pkg::*;
#(
    parameter int N         = 4,
    parameter int MAX_RETRY = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tgt_valid,
    output logic         tgt_ready,
    input  logic [N-1:0] tgt_data,
    input  logic [N-1:0] q_fb,
    output logic [N-1:0] j,
    output logic [N-1:0] k,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [N-1:0] fail_mask
);

    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_DRIVE = DRIVE;
    localparam logic [1:0] ST_CHECK = CHECK;
    localparam logic [1:0] ST_RESP  = RESP;

    logic [1:0]    state;
    logic [N-1:0]  tgt_q;
    logic [RW-1:0] retry;
    logic          resp_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            tgt_q     <= '0;
            retry     <= '0;
            fail_mask <= '0;
            resp_err  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (tgt_valid) begin
                        tgt_q     <= tgt_data;
                        retry     <= '0;
                        fail_mask <= '0;
                        resp_err  <= 1'b0;
                        state     <= ST_DRIVE;
                    end
                end
                ST_DRIVE: state <= ST_CHECK;
                ST_CHECK: begin
                    if (q_fb == tgt_q) begin
                        resp_err <= 1'b0;
                        state    <= ST_RESP;
                    end else if (retry < RETRY_LIM) begin
                        // The guard above keeps the counter saturating at RETRY_LIM.
                        retry <= retry + RW'(1);
                        state <= ST_DRIVE;
                    end else begin
                        fail_mask <= q_fb ^ tgt_q;
                        resp_err  <= 1'b1;
                        state     <= ST_RESP;
                    end
                end
                ST_RESP:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    assign tgt_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_RESP) & ~resp_err;
    assign err       = (state == ST_RESP) &  resp_err;

    jk_excite #(.N(N)) u_excite (
        .q   (q_fb),
        .tgt (tgt_q),
        .en  (state == ST_DRIVE),
        .j   (j),
        .k   (k)
    );

endmodule

// File: tb/tb_jk_driver.sv
module tb_jk_driver;

    localparam int N  = 4;
    localparam int MR = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         tgt_valid = 1'b0;
    logic         tgt_ready;
    logic [N-1:0] tgt_data = '0;
    logic [N-1:0] q_fb;
    logic [N-1:0] j, k;
    logic         busy, done, err;
    logic [N-1:0] fail_mask;

    jk_driver #(.N(N), .MAX_RETRY(MR)) dut (
        .clk       (clk),
        .rst       (rst),
        .tgt_valid (tgt_valid),
        .tgt_ready (tgt_ready),
        .tgt_data  (tgt_data),
        .q_fb      (q_fb),
        .j         (j),
        .k         (k),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .fail_mask (fail_mask)
    );

    always #5 clk = ~clk;

    // Behavioural JK bank with optional stuck-at-0 bits and a preload port.
    logic [N-1:0] bank_q = '0;
    logic [N-1:0] stuck = '0;
    logic         preset_en = 1'b0;
    logic [N-1:0] preset_val = '0;
    assign q_fb = bank_q;

    always @(posedge clk) begin
        logic [N-1:0] nq;
        nq = bank_q;
        for (int i = 0; i < N; i++) begin
            if (j[i] && k[i])  nq[i] = ~bank_q[i];
            else if (j[i])     nq[i] = 1'b1;
            else if (k[i])     nq[i] = 1'b0;
        end
        if (preset_en) nq = preset_val;
        bank_q <= nq & ~stuck;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [N-1:0] tgt;
        logic [N-1:0] q0;
        logic [N-1:0] stuck;
        logic [N-1:0] fm;
        int           acc;
        int           lat;
        bit           is_err;
    } txn_t;

    txn_t         sb[$];
    logic [N-1:0] held_fm = '0;

    // Outcome from first principles: one drive moves every movable bit to the target,
    // so only stuck bits that the target wants high can never converge.
    function automatic txn_t model(input logic [N-1:0] tgt, input logic [N-1:0] q0,
                                   input logic [N-1:0] stk, input int acc);
        txn_t t;
        t.tgt    = tgt;
        t.q0     = q0;
        t.stuck  = stk;
        t.acc    = acc;
        t.fm     = tgt & stk;
        t.is_err = (t.fm != '0);
        t.lat    = t.is_err ? 2 + 2 * MR : 2;
        return t;
    endfunction

    // Monitor / scoreboard, sampling 1 time unit after each rising edge.
    always begin
        @(posedge clk);
        #1;
        if (!rst) begin
            if (sb.size() == 0 || cyc < sb[0].acc) begin
                check("idle_ready", tgt_ready, 1);
                check("idle_outputs", {busy, done, err, j, k}, 0);
                check("idle_fail_mask", fail_mask, held_fm);
            end else begin
                txn_t e;
                int   d;
                e = sb[0];
                d = cyc - e.acc;
                check("busy_ready", {busy, tgt_ready}, 2'b10);
                if (d < e.lat) begin
                    check("no_resp_yet", {done, err}, 0);
                    check("fail_mask_cleared", fail_mask, 0);
                    if (d % 2 == 0) begin
                        logic [N-1:0] qb, mm, ej, ek;
                        qb = (d == 0) ? e.q0 : (e.tgt & ~e.stuck);
                        mm = qb ^ e.tgt;
`ifdef JK_DRV_TOGGLE_EN
                        ej = mm;
                        ek = mm;
`else
                        ej = mm & e.tgt;
                        ek = mm & ~e.tgt;
`endif
                        check("drive_j", j, ej);
                        check("drive_k", k, ek);
                    end else begin
                        check("check_jk_zero", {j, k}, 0);
                    end
                end else begin
                    check("resp_done", done, !e.is_err);
                    check("resp_err", err, e.is_err);
                    check("resp_jk_zero", {j, k}, 0);
                    check("resp_fail_mask", fail_mask, e.fm);
                    check("bank_q", q_fb, e.tgt & ~e.stuck);
                    held_fm = e.fm;
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (!tgt_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!tgt_ready) check("wait_idle_timeout", 0, 1);
    endtask

    task automatic preset(input logic [N-1:0] stk, input logic [N-1:0] v);
        wait_idle();
        stuck      = stk;
        preset_en  = 1'b1;
        preset_val = v;
        @(negedge clk);
        preset_en  = 1'b0;
    endtask

    task automatic do_txn(input logic [N-1:0] tgt, input bit noisy);
        int n = 0;
        wait_idle();
        tgt_data  = tgt;
        tgt_valid = 1'b1;
        sb.push_back(model(tgt, bank_q, stuck, cyc + 1));
        @(negedge clk);
        if (noisy) begin
            while (!tgt_ready && n < 50) begin
                tgt_data = N'($urandom);
                @(negedge clk);
                n++;
            end
        end
        tgt_valid = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        check("rst_ready", tgt_ready, 1);
        check("rst_outputs", {busy, done, err, j, k, fail_mask}, 0);
        rst = 1'b0;

        preset(4'b0000, 4'b0000);
        do_txn(4'b1010, 1'b0);
        preset(4'b0000, 4'b1100);
        do_txn(4'b0110, 1'b0);
        preset(4'b0000, 4'b0101);
        do_txn(4'b0101, 1'b0);
        preset(4'b0100, 4'b0000);
        do_txn(4'b0100, 1'b0);
        preset(4'b0000, 4'b0000);

        // Reset asserted during CHECK of an in-flight transaction.
        wait_idle();
        tgt_data  = 4'b0011;
        tgt_valid = 1'b1;
        sb.push_back(model(4'b0011, bank_q, stuck, cyc + 1));
        @(negedge clk);
        tgt_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_jk", {j, k}, 0);
        check("midrst_busy_ready", {busy, tgt_ready}, 2'b01);
        check("midrst_done_err", {done, err}, 0);
        check("midrst_fail_mask", fail_mask, 0);
        void'(sb.pop_front());
        held_fm = '0;
        @(negedge clk);
        rst = 1'b0;
        do_txn(4'b0001, 1'b0);

        preset(4'b0000, 4'b0011);
        do_txn(4'b1100, 1'b1);

        for (int t = 0; t < 40; t++) begin
            logic [N-1:0] stk;
            stk = ($urandom_range(0, 3) == 0) ? N'(1 << $urandom_range(0, N - 1)) : '0;
            preset(stk, N'($urandom));
            do_txn(N'($urandom), 1'($urandom_range(0, 1)));
        end

        wait_idle();
        repeat (4) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/jk_driver.md
# jk_driver

Sequencing controller that drives a parameterised JK flip-flop register bank, acting as the write side of the bank's J/K interface. A client hands over a target word with a valid/ready handshake. The block derives per-bit J/K excitation from the bank's current Q feedback and applies it for one clock. It then reads Q back, confirms the update, and reports done, or retries and finally reports an error. It sits between control logic and every JK register bank the team instantiates.

## Interface
- N, 4, width of target word and of the JK bank driven
- MAX_RETRY, 3, extra drive attempts after the first failed check; 0 means a single attempt
- clk  in  1  clock; shared with the driven JK bank
- rst  in  1  reset, asynchronous, active-high
- tgt_valid  in  1  target word offered
- tgt_ready  out  1  block can accept a target
- tgt_data  in  N  desired bank contents
- q_fb  in  N  Q outputs of the driven JK bank
- j  out  N  J inputs to the bank
- k  out  N  K inputs to the bank
- busy  out  1  a transaction is in progress
- done  out  1  one-cycle pulse: bank matches target
- err  out  1  one-cycle pulse: retries exhausted, bank mismatch
- fail_mask  out  N  bits still mismatching at err; held until next accept

## Operation
- The FSM has four states: IDLE, DRIVE, CHECK and RESP.
- **IDLE**
  - tgt_ready=1, busy=0, j=k=0.
  - On tgt_valid&&tgt_ready: register tgt_data into tgt_q, clear the retry counter and fail_mask, then go to DRIVE.
- **DRIVE** (exactly one cycle)
  - Excitation per bit i, from q_fb[i] and tgt_q[i]:
    - equal: j=0, k=0
    - target 1, q 0: j=1, k=0
    - target 0, q 1: j=0, k=1
  - Always go to CHECK.
- **CHECK** (j=k=0)
  - If q_fb==tgt_q: go to RESP with done flagged.
  - Else if retry<MAX_RETRY: increment retry and go to DRIVE.
  - Else: latch fail_mask=q_fb^tgt_q and go to RESP with err flagged.
- **RESP**
  - done or err is high for this single cycle; never both.
  - Then go to IDLE.
- **Outputs**
  - tgt_ready=1 only in IDLE; busy=1 in every other state.
  - j and k are combinational from the state, tgt_q and q_fb, and are zero outside DRIVE.
- **Retry counter**
  - Width is $clog2(MAX_RETRY+1), minimum 1 bit.
  - It saturates and never wraps.
- **Target equal to current Q**: DRIVE issues all-zero J/K and CHECK passes, so done follows.
- **Reset (any state, including mid-transaction)**
  - State goes to IDLE; tgt_q, retry and fail_mask clear to 0.
  - done=0, err=0, busy=0, tgt_ready=1, j=k=0 immediately (asynchronous).

## Timing
- The handshake completes at clock edge E0.
- DRIVE occupies the cycle from E0 to E1; the bank samples J/K at E1.
- CHECK occupies E1 to E2 and sees the updated q_fb, because the bank has one-cycle latency.
- RESP occupies E2 to E3, so done or err is visible 2 cycles after the accept edge.
- tgt_ready reasserts from E3.
- Each retry adds 2 cycles. Worst-case occupancy is 3+2·MAX_RETRY cycles.
- There is no back-to-back acceptance; the minimum transaction spacing is 3 cycles.
- tgt_data is sampled only at the accept edge; changes while busy are ignored.

## Configuration
- JK_DRV_TOGGLE_EN
  - Defined: every mismatching bit is driven with j=1, k=1 (toggle). Equal bits are still driven 0/0.
  - Undefined: mismatching bits use the set/reset encodings (1/0 or 0/1) listed under DRIVE.
- Against a healthy bank, both builds produce identical q_fb, done timing and outputs other than j/k.

## Structure
- Shared package jk_pkg holds:
  - the state enum (IDLE, DRIVE, CHECK, RESP);
  - the 2-bit JK encodings JK_HOLD=00, JK_RESET=01, JK_SET=10, JK_TOGGLE=11.
- Sub-module jk_excite:
  - Parameterised on N, purely combinational.
  - Maps (q, target, enable) to (j, k) and holds the JK_DRV_TOGGLE_EN selection.
  - jk_driver keeps the FSM, counters and handshake.

## Test plan
- Reset with bank Q=0000, then target 1010 accepted: DRIVE shows j=1010, k=0000; done 2 cycles after accept; q_fb=1010; err never high.
- Bank Q=1100, target 0110:
  - without macro: j=0010, k=1000;
  - with JK_DRV_TOGGLE_EN: j=k=1010;
  - both give q_fb=0110 and done.
- Target equal to Q (0101): j=k=0000 in DRIVE; done 2 cycles after accept.
- Bank model with bit 2 stuck at 0, target 0100, MAX_RETRY=3: four DRIVE cycles, then err at accept+8, fail_mask=0100, done never asserted.
- Assert rst during CHECK: j=k=0, busy=0, tgt_ready=1, fail_mask=0 immediately; next target 0001 completes normally with done.
- tgt_valid held high with changing tgt_data while busy: only the value at the accept edge is driven; tgt_ready stays low until the cycle after RESP.
